vscale_regfile_wb: RTL and testbench

- Write-side front end of the integer register file. It merges single-cycle pipeline writebacks with out-of-order-timed results from the long-latency mul/div unit.
- Drives the regfile write port (wen/wa/wd) and keeps a per-register busy scoreboard so the decode stage can stall on pending long-latency destinations.
- Long-latency results are buffered in an in-order tag/data queue and drained only on cycles when the pipeline is not writing.

---
 rtl/vscale_regfile_wb.sv | 131 +++++++++++++
 tb/tb_vscale_regfile_wb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_regfile_wb.sv
// Register file write front end: merges pipeline writebacks with queued
// long-latency results and tracks pending destinations in a busy scoreboard.
module vscale_regfile_wb #(
  parameter int XPR_LEN        = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MD_DEPTH       = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pipe_wen,
  input  logic [REG_ADDR_WIDTH-1:0] pipe_wa,
  input  logic [XPR_LEN-1:0]        pipe_wd,
  input  logic                      md_issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0] md_issue_wa,
  output logic                      md_issue_ready,
  input  logic                      md_resp_valid,
  input  logic [XPR_LEN-1:0]        md_resp_data,
  output logic                      md_resp_ready,
  input  logic [REG_ADDR_WIDTH-1:0] ra1,
  input  logic [REG_ADDR_WIDTH-1:0] ra2,
  output logic                      busy1,
  output logic                      busy2,
  output logic                      wen,
  output logic [REG_ADDR_WIDTH-1:0] wa,
  output logic [XPR_LEN-1:0]        wd
);

  localparam int PTR_W = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1;
  localparam int CNT_W = $clog2(MD_DEPTH + 1);
  localparam int NREGS = 2 ** REG_ADDR_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(MD_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MD_DEPTH - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } entry_state_t;

  entry_state_t              ent_state [MD_DEPTH];
  logic [REG_ADDR_WIDTH-1:0] ent_tag   [MD_DEPTH];
  logic [XPR_LEN-1:0]        ent_data  [MD_DEPTH];

  logic [PTR_W-1:0]          head;
  logic [PTR_W-1:0]          tail;
  logic [PTR_W-1:0]          fill;
  logic [CNT_W-1:0]          count;
  logic [NREGS-1:0]          busy;
  logic                      clr_pend;
  logic [REG_ADDR_WIDTH-1:0] clr_wa;

  logic pipe_write;
  logic drain;
  logic issue_acc;
  logic resp_acc;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) return '0;
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    md_issue_ready = (count < DEPTH_C) && !((md_issue_wa != '0) && busy[md_issue_wa]);
    md_resp_ready  = (ent_state[fill] == WAIT);
    busy1          = (ra1 != '0) && busy[ra1];
    busy2          = (ra2 != '0) && busy[ra2];
    pipe_write     = pipe_wen && (pipe_wa != '0);
    drain          = !pipe_write && (ent_state[head] == READY);
    issue_acc      = md_issue_valid && md_issue_ready;
    resp_acc       = md_resp_valid && md_resp_ready;
  end

  // Busy is cleared one edge after the drained write appears on wen, so a
  // decode that sees busy low is guaranteed the regfile already holds the value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MD_DEPTH; i++) begin
        ent_state[i] <= EMPTY;
        ent_tag[i]   <= '0;
        ent_data[i]  <= '0;
      end
      head     <= '0;
      tail     <= '0;
      fill     <= '0;
      count    <= '0;
      busy     <= '0;
      clr_pend <= 1'b0;
      clr_wa   <= '0;
      wen      <= 1'b0;
      wa       <= '0;
      wd       <= '0;
    end else begin
      if (issue_acc) begin
        ent_state[tail] <= WAIT;
        ent_tag[tail]   <= md_issue_wa;
        tail            <= inc_ptr(tail);
        if (md_issue_wa != '0) busy[md_issue_wa] <= 1'b1;
      end

      if (resp_acc) begin
        ent_state[fill] <= READY;
        ent_data[fill]  <= md_resp_data;
        fill            <= inc_ptr(fill);
      end

      if (drain) begin
        ent_state[head] <= EMPTY;
        head            <= inc_ptr(head);
      end

      if (clr_pend) busy[clr_wa] <= 1'b0;
      clr_pend <= drain && (ent_tag[head] != '0);
      clr_wa   <= ent_tag[head];

      count <= count + CNT_W'(issue_acc) - CNT_W'(drain);

      if (pipe_write) begin
        wen <= 1'b1;
        wa  <= pipe_wa;
        wd  <= pipe_wd;
      end else if (drain) begin
        wen <= (ent_tag[head] != '0);
        wa  <= ent_tag[head];
        wd  <= ent_data[head];
      end else begin
        wen <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vscale_regfile_wb.sv
// Directed bench for vscale_regfile_wb: pipeline writes, queued mul/div
// results, contention, full/WAW refusal and reset while ops are pending.
module tb_vscale_regfile_wb;

  logic        clk;
  logic        reset;
  logic        pipe_wen;
  logic [4:0]  pipe_wa;
  logic [31:0] pipe_wd;
  logic        md_issue_valid;
  logic [4:0]  md_issue_wa;
  logic        md_issue_ready;
  logic        md_resp_valid;
  logic [31:0] md_resp_data;
  logic        md_resp_ready;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        busy1;
  logic        busy2;
  logic        wen;
  logic [4:0]  wa;
  logic [31:0] wd;

  int vec_count = 0;
  int err_count = 0;

  vscale_regfile_wb #(
    .XPR_LEN(32),
    .REG_ADDR_WIDTH(5),
    .MD_DEPTH(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pipe_wen(pipe_wen),
    .pipe_wa(pipe_wa),
    .pipe_wd(pipe_wd),
    .md_issue_valid(md_issue_valid),
    .md_issue_wa(md_issue_wa),
    .md_issue_ready(md_issue_ready),
    .md_resp_valid(md_resp_valid),
    .md_resp_data(md_resp_data),
    .md_resp_ready(md_resp_ready),
    .ra1(ra1),
    .ra2(ra2),
    .busy1(busy1),
    .busy2(busy2),
    .wen(wen),
    .wa(wa),
    .wd(wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec_count++;
    if (obs !== expv) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic applyStimulus(input logic pwen, input logic [4:0] pwa, input logic [31:0] pwd,
                               input logic iv, input logic [4:0] iwa,
                               input logic rv, input logic [31:0] rdata);
    pipe_wen       = pwen;
    pipe_wa        = pwa;
    pipe_wd        = pwd;
    md_issue_valid = iv;
    md_issue_wa    = iwa;
    md_resp_valid  = rv;
    md_resp_data   = rdata;
    #1;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    ra1   = 5'd7;
    ra2   = 5'd3;
    applyIdle();
    stepCycle();
    stepCycle();
    reset = 1'b0;
    stepCycle();

    $display("[TB] reset state");
    checkOutput("rst_wen", wen, 0);
    checkOutput("rst_wa", wa, 0);
    checkOutput("rst_wd", wd, 0);
    checkOutput("rst_busy1", busy1, 0);
    checkOutput("rst_busy2", busy2, 0);
    checkOutput("rst_resp_ready", md_resp_ready, 0);
    checkOutput("rst_issue_ready", md_issue_ready, 1);

    $display("[TB] pipeline writes");
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 32'h0);
    stepCycle();
    checkOutput("pipe_wen", wen, 1);
    checkOutput("pipe_wa", wa, 5);
    checkOutput("pipe_wd", wd, 32'hDEADBEEF);
    applyStimulus(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 1'b0, 32'h0);
    stepCycle();
    checkOutput("pipe_x0_wen", wen, 0);
    checkOutput("pipe_x0_wa_hold", wa, 5);
    checkOutput("pipe_x0_wd_hold", wd, 32'hDEADBEEF);

    $display("[TB] single long-latency op");
    ra1 = 5'd7;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 32'h0);
    checkOutput("md7_issue_ready", md_issue_ready, 1);
    checkOutput("md7_busy_pre", busy1, 0);
    stepCycle();
    applyIdle();
    checkOutput("md7_busy_set", busy1, 1);
    checkOutput("md7_resp_ready", md_resp_ready, 1);
    checkOutput("md7_wen_idle", wen, 0);
    stepCycle();
    stepCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'h1234);
    checkOutput("md7_resp_ready_t3", md_resp_ready, 1);
    stepCycle();
    applyIdle();
    checkOutput("md7_wen_t4", wen, 0);
    checkOutput("md7_busy_t4", busy1, 1);
    stepCycle();
    checkOutput("md7_wen_t5", wen, 1);
    checkOutput("md7_wa_t5", wa, 7);
    checkOutput("md7_wd_t5", wd, 32'h1234);
    checkOutput("md7_busy_t5", busy1, 1);
    stepCycle();
    checkOutput("md7_busy_t6", busy1, 0);
    checkOutput("md7_wen_t6", wen, 0);
    checkOutput("md7_resp_ready_t6", md_resp_ready, 0);

    $display("[TB] pipeline contention");
    ra2 = 5'd9;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 32'h0);
    stepCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'h9999);
    stepCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'(10 + i), 32'hA0 + 32'(i), 1'b0, 5'd0, 1'b0, 32'h0);
      stepCycle();
      checkOutput("cont_pipe_wen", wen, 1);
      checkOutput("cont_pipe_wa", wa, 32'(10 + i));
      checkOutput("cont_pipe_wd", wd, 32'hA0 + 32'(i));
      checkOutput("cont_busy9", busy2, 1);
    end
    applyIdle();
    stepCycle();
    checkOutput("cont_drain_wen", wen, 1);
    checkOutput("cont_drain_wa", wa, 9);
    checkOutput("cont_drain_wd", wd, 32'h9999);
    stepCycle();
    checkOutput("cont_after_wen", wen, 0);
    checkOutput("cont_busy9_clr", busy2, 0);

    $display("[TB] op targeting x0");
    ra1 = 5'd0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 32'h0);
    checkOutput("x0_issue_ready", md_issue_ready, 1);
    stepCycle();
    applyIdle();
    checkOutput("x0_busy", busy1, 0);
    checkOutput("x0_resp_ready", md_resp_ready, 1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'h77);
    stepCycle();
    applyIdle();
    checkOutput("x0_wen_ready", wen, 0);
    stepCycle();
    checkOutput("x0_drain_wen", wen, 0);
    checkOutput("x0_drain_wa", wa, 0);
    checkOutput("x0_drain_wd", wd, 32'h77);
    checkOutput("x0_resp_ready_after", md_resp_ready, 0);

    $display("[TB] queue full and WAW refusal");
    ra1 = 5'd3;
    ra2 = 5'd4;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 32'h0);
    checkOutput("full_issue3_ready", md_issue_ready, 1);
    stepCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 1'b0, 32'h0);
    checkOutput("waw3_refused", md_issue_ready, 0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 32'h0);
    checkOutput("full_issue4_ready", md_issue_ready, 1);
    stepCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 1'b0, 32'h0);
    checkOutput("full_refused", md_issue_ready, 0);
    checkOutput("full_busy3", busy1, 1);
    checkOutput("full_busy4", busy2, 1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 1'b1, 32'hAAAA0003);
    stepCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 1'b1, 32'hBBBB0004);
    checkOutput("full_while_drain", md_issue_ready, 0);
    checkOutput("full_resp_b_ready", md_resp_ready, 1);
    stepCycle();
    applyIdle();
    checkOutput("order_a_wen", wen, 1);
    checkOutput("order_a_wa", wa, 3);
    checkOutput("order_a_wd", wd, 32'hAAAA0003);
    stepCycle();
    checkOutput("order_b_wen", wen, 1);
    checkOutput("order_b_wa", wa, 4);
    checkOutput("order_b_wd", wd, 32'hBBBB0004);
    checkOutput("order_busy3_clr", busy1, 0);
    checkOutput("order_busy4_held", busy2, 1);
    stepCycle();
    checkOutput("order_end_wen", wen, 0);
    checkOutput("order_busy4_clr", busy2, 0);
    checkOutput("order_issue_ready", md_issue_ready, 1);

    $display("[TB] reset with pending ops");
    ra1 = 5'd6;
    ra2 = 5'd8;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b0, 32'h0);
    stepCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 1'b0, 32'h0);
    stepCycle();
    applyIdle();
    checkOutput("midrst_busy6_pre", busy1, 1);
    checkOutput("midrst_busy8_pre", busy2, 1);
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'h5555);
    checkOutput("midrst_resp_ready", md_resp_ready, 0);
    checkOutput("midrst_busy6", busy1, 0);
    checkOutput("midrst_busy8", busy2, 0);
    checkOutput("midrst_wen", wen, 0);
    checkOutput("midrst_wd", wd, 0);
    checkOutput("midrst_issue_ready", md_issue_ready, 1);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("midrst_no_wen", wen, 0);
      checkOutput("midrst_resp_blocked", md_resp_ready, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
